// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, state and flag types for alu_seq
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic dz;
  } flags_t;
  localparam int FLG_CARRY = 4;
  localparam int FLG_ZERO = 3;
  localparam int FLG_NEG = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_DZ = 0;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand and result valid/ready bundle for alu_seq
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic in_valid, in_ready, out_valid, out_ready;
  op_e op;
  logic [WIDTH-1:0] a, b, result, result_hi;
  flags_t flags;
  modport master (
    output in_valid, op, a, b, out_ready,
    input in_ready, out_valid, result, result_hi, flags
  );
  modport slave (
    input in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, flags
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, m_q, m_d;
  logic [WIDTH:0] add, shl, trial;
  assign busy = cnt_q != '0;
  assign done = busy && cnt_q == CW'(1);
  assign lo = lo_q;
  assign hi = hi_q;
  assign add = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {WIDTH{1'b0}})};
  assign shl = {hi_q, lo_q[WIDTH-1]};
  assign trial = shl - {1'b0, m_q};
  // {hi,lo} is the product accumulator for MUL, {remainder,quotient} for DIV
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    lo_d = lo_q;
    hi_d = hi_q;
    m_d = m_q;
    if (start) begin
      cnt_d = CW'(WIDTH);
      div_d = is_div;
      lo_d = a;
      hi_d = '0;
      m_d = b;
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      hi_d = div_q ? (trial[WIDTH] ? shl[WIDTH-1:0] : trial[WIDTH-1:0]) : add[WIDTH:1];
      lo_d = div_q ? {lo_q[WIDTH-2:0], ~trial[WIDTH]} : {add[0], lo_q[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      m_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      m_q <= m_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes, status flags and
// iterative full-precision multiply/divide
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  logic [1:0] sync_q, sync_d;
  logic rst_s_n;
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, alu_r, alu_h, md_lo, md_hi, rol, ror;
  flags_t flg_q, flg_d, alu_f, md_f;
  logic accept, start, md_busy, md_done, in_ready, out_valid;
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum, dif, sl, sr;
  // assertion clears everything at once, release waits two edges
  assign sync_d = {sync_q[0], 1'b1};
  assign rst_s_n = sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign sh = bus.b[SHW-1:0];
  assign accept = bus.in_valid && in_ready;
  assign start = accept && (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0));
  assign sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif = {1'b0, bus.a} - {1'b0, bus.b};
  assign sl = {1'b0, bus.a} << sh;
  assign sr = {bus.a, 1'b0} >> sh;
  assign rol = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
  assign ror = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
  always_comb begin
    alu_r = '0;
    alu_h = '0;
    alu_f = '0;
    case (bus.op)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_f.carry = sum[WIDTH];
        alu_f.ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = dif[WIDTH-1:0];
        alu_f.carry = dif[WIDTH];
        alu_f.ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_DIV: begin
        alu_r = '1;
        alu_h = bus.a;
        alu_f.dz = 1'b1;
      end
      OP_SHL: begin
        alu_r = sl[WIDTH-1:0];
        alu_f.carry = sl[WIDTH];
      end
      OP_SHR: begin
        alu_r = sr[WIDTH:1];
        alu_f.carry = sr[0];
      end
      OP_ROL: begin
        alu_r = rol;
        alu_f.carry = sh != '0 && rol[0];
      end
      OP_ROR: begin
        alu_r = ror;
        alu_f.carry = sh != '0 && ror[WIDTH-1];
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR: alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_NOR: alu_r = ~(bus.a | bus.b);
      OP_NAND: alu_r = ~(bus.a & bus.b);
      OP_XNOR: alu_r = ~(bus.a ^ bus.b);
      OP_GT: alu_r = WIDTH'(bus.a > bus.b);
      OP_EQ: alu_r = WIDTH'(bus.a == bus.b);
      default: alu_r = '0;
    endcase
    alu_f.zero = alu_r == '0;
    alu_f.neg = alu_r[WIDTH-1];
  end
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk(clk),
    .rst_n(rst_s_n),
    .start(start),
    .is_div(bus.op == OP_DIV),
    .a(bus.a),
    .b(bus.b),
    .busy(md_busy),
    .done(md_done),
    .lo(md_lo),
    .hi(md_hi)
  );
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (bus.op == OP_MUL) ? S_MUL : start ? S_DIV : S_DONE;
      S_MUL, S_DIV: if (md_done) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q == S_IDLE && !md_busy;
    out_valid = state_q == S_DONE;
  end
  // iterative results are read straight from the idle datapath, which holds them
  always_comb begin
    op_d = accept ? bus.op : op_q;
    sel_d = accept ? start : sel_q;
    res_d = (accept && !start) ? alu_r : res_q;
    hi_d = (accept && !start) ? alu_h : hi_q;
    flg_d = (accept && !start) ? alu_f : flg_q;
    md_f = '0;
    md_f.carry = op_q == OP_MUL && |md_hi;
    md_f.zero = md_lo == '0;
    md_f.neg = md_lo[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      op_q <= OP_ADD;
      sel_q <= 1'b0;
      res_q <= '0;
      hi_q <= '0;
      flg_q <= '0;
    end else begin
      op_q <= op_d;
      sel_q <= sel_d;
      res_q <= res_d;
      hi_q <= hi_d;
      flg_q <= flg_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result = sel_q ? md_lo : res_q;
  assign bus.result_hi = sel_q ? md_hi : hi_q;
  assign bus.flags = sel_q ? md_f : flg_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; expectations come from an
// arithmetic reference model, a monitor checks every presented result
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 16;
  localparam longint MASK = 64'hFFFF;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0] flg;
    int lat;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic rnd_rdy = 1'b0;
  logic seen = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r = 0;
    longint h = 0;
    int n = int'(b % W);
    int sa = $signed(a);
    int sb = $signed(b);
    int s;
    bit c = 0, v = 0, dz = 0;
    case (op)
      4'h0: begin r = ua + ub; c = r > MASK; s = sa + sb; v = s > 32767 || s < -32768; end
      4'h1: begin r = ua - ub; c = ua < ub; s = sa - sb; v = s > 32767 || s < -32768; end
      4'h2: begin r = ua * ub; h = r >> W; c = h != 0; end
      4'h3: if (ub == 0) begin r = MASK; h = ua; dz = 1; end
            else begin r = ua / ub; h = ua % ub; end
      4'h4: begin r = ua << n; c = n != 0 && ((ua >> (W - n)) & 1) != 0; end
      4'h5: begin r = ua >> n; c = n != 0 && ((ua >> (n - 1)) & 1) != 0; end
      4'h6: begin r = (ua << n) | (ua >> (W - n)); c = n != 0 && ((ua >> (W - n)) & 1) != 0; end
      4'h7: begin r = (ua >> n) | (ua << (W - n)); c = n != 0 && ((ua >> (n - 1)) & 1) != 0; end
      4'h8: r = ua & ub;
      4'h9: r = ua | ub;
      4'hA: r = ua ^ ub;
      4'hB: r = ~(ua | ub);
      4'hC: r = ~(ua & ub);
      4'hD: r = ~(ua ^ ub);
      4'hE: r = (ua > ub) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    r = r & MASK;
    h = h & MASK;
    e.res = W'(r);
    e.hi = W'(h);
    e.flg = {c, r == 0, r >= 64'h8000, v, dz};
    e.lat = (op == 4'h2 || (op == 4'h3 && b != 0)) ? W + 1 : 1;
    e.acc = 0;
    return e;
  endfunction
  task automatic issue(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e = model(op, a, b);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op_e'(op);
    bus.a = a;
    bus.b = b;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    // stray requests while the block is busy must be ignored
    if (e.lat > 1) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (!bus.in_ready) begin
          bus.in_valid = 1'b1;
          bus.op = op_e'($urandom_range(0, 15));
          bus.a = W'($urandom);
          bus.b = W'($urandom);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
      end
    end
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = hold ? 1'b0 : rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    if (exp_q.size() == 0) chk("no_unexpected_out_valid", bus.out_valid, 0);
    else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
      end
      chk("in_ready_in_done", bus.in_ready, 0);
      chk("result", bus.result, exp_q[0].res);
      chk("result_hi", bus.result_hi, exp_q[0].hi);
      chk("flags", bus.flags, exp_q[0].flg);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_result_hi", bus.result_hi, 0);
    chk("reset_flags", bus.flags, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(4'h0, 16'hFFFF, 16'h0001);
    issue(4'h1, 16'h8000, 16'h0001);
    issue(4'h1, 16'h0001, 16'h0002);
    issue(4'h2, 16'h1234, 16'h5678);
    issue(4'h3, 16'd1000, 16'd7);
    issue(4'h3, 16'h00AB, 16'h0000);
    issue(4'h6, 16'h8001, 16'd4);
    issue(4'h5, 16'h00F1, 16'd4);
    issue(4'h4, 16'h8000, 16'd1);
    issue(4'h2, 16'hFFFF, 16'hFFFF);
    issue(4'h3, 16'hFFFF, 16'h0001);
    issue(4'h7, 16'h0001, 16'd0);
    drain();
    hold = 1'b1;
    issue(4'h2, 16'h00FF, 16'h0101);
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    hold = 1'b0;
    drain();
    issue(4'h3, 16'd1000, 16'd7);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midop_reset_out_valid", bus.out_valid, 0);
    chk("midop_reset_in_ready", bus.in_ready, 1);
    chk("midop_reset_result", bus.result, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++)
      issue(4'($urandom_range(0, 15)), W'($urandom),
            ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
